// File: rtl/i2s_pkg.sv
// i2s_pkg: shared constants and types for the I2S playback serializer.
//   FRAME_BITS  - bits per stereo frame (left in [63:32], right in [31:0])
//   SLOT_W      - width of the 64-slot bit counter
//   SLOT_FETCH  - slot on whose entry the next FIFO word is requested
//   SLOT_LOAD   - slot on whose entry the held word moves into the shifter
//   IDLE_SLOT   - slot the counter parks at while disabled, so the first
//                 fall event after enable lands on SLOT_FETCH
//   fetch_state_e - FIFO fetch tracker state
//   i2s_dbg_t   - debug bundle exposed by the top for checkers
package i2s_pkg;

  localparam int FRAME_BITS = 64;
  localparam int SLOT_W     = $clog2(FRAME_BITS);

  localparam logic [SLOT_W-1:0] SLOT_FETCH = SLOT_W'(48);
  localparam logic [SLOT_W-1:0] SLOT_LOAD  = SLOT_W'(1);
  localparam logic [SLOT_W-1:0] IDLE_SLOT  = SLOT_W'(47);

  localparam logic [15:0] UNDERRUN_CNT_MAX = 16'hFFFF;

  typedef enum logic {
    FETCH_IDLE = 1'b0,
    FETCH_PEND = 1'b1
  } fetch_state_e;

  typedef struct packed {
    fetch_state_e      fetch_state;
    logic [SLOT_W-1:0] slot;
    logic              bclk_rise;
    logic              bclk_fall;
  } i2s_dbg_t;

endpackage

// File: rtl/i2s_playback_tx_bclk_gen.sv
// i2s_bclk_gen: BCLK divider for the I2S playback serializer.
//   clk_i    - block clock
//   reset_i  - asynchronous active-high reset
//   enable_i - 1 = run divider, 0 = hold divider at 0 with BCLK low
//   bclk_o   - registered bit clock, half-period = BCLK_DIV clk
//   rise_o   - one-clk strobe, high in the clk whose edge drives BCLK 0->1
//   fall_o   - one-clk strobe, high in the clk whose edge drives BCLK 1->0
// Parameter BCLK_DIV: clk cycles per BCLK half-period, 2..255.
module i2s_bclk_gen #(
  parameter int BCLK_DIV = 4
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic enable_i,
  output logic bclk_o,
  output logic rise_o,
  output logic fall_o
);

  localparam logic [7:0] DIV_LAST = 8'(BCLK_DIV - 1);

  logic [7:0] div_cnt_q, div_cnt_d;
  logic       bclk_q, bclk_d;
  logic       term;

  // The strobes coincide with the edge that toggles BCLK, so the top can
  // update its own registers on exactly that edge.
  assign term   = enable_i && (div_cnt_q == DIV_LAST);
  assign rise_o = term && !bclk_q;
  assign fall_o = term && bclk_q;
  assign bclk_o = bclk_q;

  always_comb begin
    div_cnt_d = div_cnt_q;
    bclk_d    = bclk_q;
    if (!enable_i) begin
      div_cnt_d = '0;
      bclk_d    = 1'b0;
    end else if (term) begin
      div_cnt_d = '0;
      bclk_d    = ~bclk_q;
    end else begin
      div_cnt_d = div_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      div_cnt_q <= '0;
      bclk_q    <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      bclk_q    <= bclk_d;
    end
  end

endmodule

// File: rtl/i2s_playback_tx.sv
// i2s_playback_tx: master-mode I2S serializer at the read end of the
// playback FIFO. Emits BCLK, LRCLK and MSB-first SDATA with the one-BCLK
// I2S delay; one 64-bit stereo frame per 64 BCLK slots.
//   clk_i          - FIFO read clock / block clock
//   reset_i        - asynchronous active-high reset
//   enable_i       - level; 1 = transmit, 0 = idle
//   fifo_data_i    - FIFO q (non-show-ahead, valid one clk after read)
//   fifo_read_o    - one-clk read pulse to FIFO
//   fifo_empty_i   - FIFO read-side empty
//   i2s_bclk_o     - bit clock
//   i2s_lrclk_o    - word select; 0 = left, 1 = right
//   i2s_sdata_o    - serial data
//   underrun_o     - sticky underrun flag
//   underrun_clr_i - one-clk pulse clearing the flag (and the count)
//   dbg_o          - fetch state, slot counter and BCLK strobes
//   underrun_count_o [15:0] - saturating underrun count, present only
//                             when I2S_TX_UNDERRUN_CNT_EN is defined
//
// FIFO handshake: the FIFO is "valid" whenever fifo_empty_i=0; this block
// is "ready" only on the fall event entering SLOT_FETCH, where it issues a
// single fifo_read_o pulse. The word appears on fifo_data_i in the clk
// after the pulse and is captured at the end of that clk.
module i2s_playback_tx
  import i2s_pkg::*;
#(
  parameter int BCLK_DIV = 4
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  enable_i,
  input  logic [FRAME_BITS-1:0] fifo_data_i,
  output logic                  fifo_read_o,
  input  logic                  fifo_empty_i,
  output logic                  i2s_bclk_o,
  output logic                  i2s_lrclk_o,
  output logic                  i2s_sdata_o,
  output logic                  underrun_o,
  input  logic                  underrun_clr_i,
  output i2s_dbg_t              dbg_o
`ifdef I2S_TX_UNDERRUN_CNT_EN
  ,
  output logic [15:0]           underrun_count_o
`endif
);

  logic rise, fall;

  i2s_bclk_gen #(.BCLK_DIV(BCLK_DIV)) u_bclk_gen (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .enable_i (enable_i),
    .bclk_o   (i2s_bclk_o),
    .rise_o   (rise),
    .fall_o   (fall)
  );

  logic [SLOT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic [FRAME_BITS-1:0] hold_q, hold_d;
  fetch_state_e          fetch_q, fetch_d;
  logic                  fifo_read_q, fifo_read_d;
  logic                  lrclk_q, lrclk_d;
  logic                  sdata_q, sdata_d;
  logic                  underrun_q, underrun_d;
  logic                  underrun_ev;

  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    fetch_d     = fetch_q;
    fifo_read_d = 1'b0;
    lrclk_d     = lrclk_q;
    sdata_d     = sdata_q;
    underrun_ev = 1'b0;
    if (!enable_i) begin
      // Idle parks one slot before the fetch slot; any word in flight is
      // dropped because fetch_q returns to idle before it can be captured.
      bit_cnt_d = IDLE_SLOT;
      shift_d   = '0;
      hold_d    = '0;
      fetch_d   = FETCH_IDLE;
      lrclk_d   = 1'b1;
      sdata_d   = 1'b0;
    end else begin
      // Capture once the read pulse has retired: FIFO q is valid now.
      if (fetch_q == FETCH_PEND && !fifo_read_q) begin
        hold_d  = fifo_data_i;
        fetch_d = FETCH_IDLE;
      end
      if (fall) begin
        bit_cnt_d = bit_cnt_q + 1'b1;
        lrclk_d   = bit_cnt_d[SLOT_W-1];
        if (bit_cnt_d == SLOT_LOAD) begin
          shift_d = hold_q;
          sdata_d = hold_q[FRAME_BITS-1];
        end else begin
          shift_d = {shift_q[FRAME_BITS-2:0], 1'b0};
          sdata_d = shift_q[FRAME_BITS-2];
        end
        if (bit_cnt_d == SLOT_FETCH) begin
          if (!fifo_empty_i) begin
            fifo_read_d = 1'b1;
            fetch_d     = FETCH_PEND;
          end else begin
            hold_d      = '0;
            underrun_ev = 1'b1;
          end
        end
      end
    end
  end

  // A new underrun outranks a simultaneous clear.
  always_comb begin
    underrun_d = underrun_q;
    if (underrun_ev)         underrun_d = 1'b1;
    else if (underrun_clr_i) underrun_d = 1'b0;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      hold_q      <= '0;
      fetch_q     <= FETCH_IDLE;
      fifo_read_q <= 1'b0;
      lrclk_q     <= 1'b0;
      sdata_q     <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      fetch_q     <= fetch_d;
      fifo_read_q <= fifo_read_d;
      lrclk_q     <= lrclk_d;
      sdata_q     <= sdata_d;
      underrun_q  <= underrun_d;
    end
  end

  assign fifo_read_o = fifo_read_q;
  assign i2s_lrclk_o = lrclk_q;
  assign i2s_sdata_o = sdata_q;
  assign underrun_o  = underrun_q;

  assign dbg_o.fetch_state = fetch_q;
  assign dbg_o.slot        = bit_cnt_q;
  assign dbg_o.bclk_rise   = rise;
  assign dbg_o.bclk_fall   = fall;

`ifdef I2S_TX_UNDERRUN_CNT_EN
  logic [15:0] underrun_cnt_q, underrun_cnt_d;

  // Clear coinciding with an event restarts the count at 1.
  always_comb begin
    underrun_cnt_d = underrun_cnt_q;
    if (underrun_clr_i)
      underrun_cnt_d = underrun_ev ? 16'd1 : 16'd0;
    else if (underrun_ev && underrun_cnt_q != UNDERRUN_CNT_MAX)
      underrun_cnt_d = underrun_cnt_q + 16'd1;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) underrun_cnt_q <= '0;
    else         underrun_cnt_q <= underrun_cnt_d;
  end

  assign underrun_count_o = underrun_cnt_q;
`endif

endmodule

// File: tb/tb_i2s_playback_tx.sv
// tb_i2s_playback_tx: directed bench for i2s_playback_tx with BCLK_DIV=4.
// A registered FIFO model feeds the DUT; SDATA is collected per slot and
// reassembled into frames (slot k -> bit 64-k, slot 0 -> bit 0).
module tb_i2s_playback_tx;
  import i2s_pkg::*;

  localparam int BCLK_DIV = 4;
  localparam int MAXW     = 1200;

  localparam logic [63:0] W1 = 64'hA5A5_0001_8000_00FF;
  localparam logic [63:0] W2 = 64'h1234_5678_9ABC_DEF0;
  localparam logic [63:0] W3 = 64'h0F0F_F0F0_3C3C_C3C3;
  localparam logic [63:0] W5 = 64'hDEAD_BEEF_0BAD_F00D;
  localparam logic [63:0] W6 = 64'hC001_D00D_5555_AAAA;
  localparam logic [63:0] W7 = 64'h8000_0000_0000_0001;
  localparam logic [63:0] SENT = 64'hBAD0_BAD0_BAD0_BAD0;

  // ---------------- clock / reset / DUT ----------------
  logic        clk;
  logic        reset, enable, fifo_empty, underrun_clr;
  logic [63:0] fifo_data;
  logic        fifo_read_o, i2s_bclk_o, i2s_lrclk_o, i2s_sdata_o, underrun_o;
  i2s_dbg_t    dbg;
`ifdef I2S_TX_UNDERRUN_CNT_EN
  logic [15:0] underrun_count;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  i2s_playback_tx #(.BCLK_DIV(BCLK_DIV)) dut (
    .clk_i          (clk),
    .reset_i        (reset),
    .enable_i       (enable),
    .fifo_data_i    (fifo_data),
    .fifo_read_o    (fifo_read_o),
    .fifo_empty_i   (fifo_empty),
    .i2s_bclk_o     (i2s_bclk_o),
    .i2s_lrclk_o    (i2s_lrclk_o),
    .i2s_sdata_o    (i2s_sdata_o),
    .underrun_o     (underrun_o),
    .underrun_clr_i (underrun_clr),
    .dbg_o          (dbg)
`ifdef I2S_TX_UNDERRUN_CNT_EN
    ,
    .underrun_count_o (underrun_count)
`endif
  );

  // ---------------- bench state ----------------
  logic [63:0] fifo_q[$];
  logic [63:0] rx_q[$];
  logic [63:0] got;
  int total, bad;
  int slot, cyc_since_fall, last_period;
  int n_reads, read_slot, read_lag;
  int lr_err, double_rd, rd_empty, read_while_off;
  logic prev_bclk, prev_rd, fall_seen;

  // ---------------- driver tasks ----------------
  task automatic push(input logic [63:0] w);
    fifo_q.push_back(w);
    fifo_empty = 1'b0;
  endtask

  // One clk: FIFO model reacts to the read pulse seen at the edge, then
  // outputs are observed 1 time unit after the edge.
  task automatic cycle();
    logic rd, en;
    rd = fifo_read_o;
    en = enable;
    @(posedge clk);
    #1;
    if (rd) begin
      if (fifo_q.size() > 0) fifo_data = fifo_q.pop_front();
      else begin fifo_data = SENT; rd_empty++; end
    end
    fifo_empty = (fifo_q.size() == 0);
    cyc_since_fall++;
    fall_seen = 1'b0;
    if (en && prev_bclk && !i2s_bclk_o) begin
      fall_seen   = 1'b1;
      slot        = (slot + 1) % 64;
      last_period = cyc_since_fall;
      cyc_since_fall = 0;
      if (i2s_lrclk_o !== (slot >= 32)) lr_err++;
      if (slot == 0) begin
        got[0] = i2s_sdata_o;
        rx_q.push_back(got);
        got = '0;
      end else begin
        got[64-slot] = i2s_sdata_o;
      end
    end
    prev_bclk = i2s_bclk_o;
    if (fifo_read_o) begin
      n_reads++;
      read_slot = slot;
      read_lag  = cyc_since_fall;
      if (prev_rd) double_rd++;
      if (!en) read_while_off++;
    end
    prev_rd = fifo_read_o;
  endtask

  task automatic wait_slot(input int s);
    int n;
    n = 0;
    do begin
      cycle();
      n++;
    end while (!(fall_seen && slot == s) && n < MAXW);
    total++;
    if (!(fall_seen && slot == s)) begin
      bad++;
      $display("FAIL wait_slot: no fall into slot %0d within %0d clk (now slot %0d)", s, MAXW, slot);
    end
  endtask

  task automatic clr_pulse();
    underrun_clr = 1'b1;
    cycle();
    underrun_clr = 1'b0;
  endtask

  task automatic restart_tracking(input int s);
    slot = s;
    got  = '0;
    rx_q.delete();
    cyc_since_fall = 0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b0; enable = 1'b0; underrun_clr = 1'b0;
    fifo_empty = 1'b1; fifo_data = '0;
    #2 reset = 1'b1;
    #1;
    total++;
    if ({fifo_read_o, i2s_bclk_o, i2s_lrclk_o, i2s_sdata_o, underrun_o} !== 5'b0) begin
      bad++;
      $display("FAIL reset_outputs: got rd/bclk/lr/sd/ur=%b required 00000",
               {fifo_read_o, i2s_bclk_o, i2s_lrclk_o, i2s_sdata_o, underrun_o});
    end
    cycle();
    total++;
    if (dbg.slot !== 6'd0 || dbg.fetch_state !== FETCH_IDLE) begin
      bad++;
      $display("FAIL reset_state: slot=%0d fetch=%0d required slot=0 fetch=0", dbg.slot, dbg.fetch_state);
    end
    reset = 1'b0;
    cycle();
    total++;
    if (i2s_lrclk_o !== 1'b1 || i2s_bclk_o !== 1'b0 || i2s_sdata_o !== 1'b0 || dbg.slot !== 6'd47) begin
      bad++;
      $display("FAIL idle_after_reset: lr=%b bclk=%b sd=%b slot=%0d required lr=1 bclk=0 sd=0 slot=47",
               i2s_lrclk_o, i2s_bclk_o, i2s_sdata_o, dbg.slot);
    end
    prev_bclk = 1'b0;
    restart_tracking(47);
  endtask

  task automatic test_stream();
    logic [63:0] f;
    push(W1);
    push(W2);
    n_reads = 0;
    enable = 1'b1;
    wait_slot(0);
    total++;
    if (n_reads !== 1 || read_slot !== 48 || read_lag !== 0) begin
      bad++;
      $display("FAIL first_fetch: reads=%0d slot=%0d lag=%0d required 1/48/0", n_reads, read_slot, read_lag);
    end
    wait_slot(0);
    total++;
    if (rx_q.size() !== 2) begin
      bad++;
      $display("FAIL stream_frames: got %0d frames required 2", rx_q.size());
    end
    f = (rx_q.size() > 0) ? rx_q.pop_front() : SENT;
    total++;
    if (f !== 64'h0) begin
      bad++;
      $display("FAIL lead_in_frame: got %h required 0", f);
    end
    f = (rx_q.size() > 0) ? rx_q.pop_front() : SENT;
    total++;
    if (f !== W1) begin
      bad++;
      $display("FAIL stream_w1: got %h required %h", f, W1);
    end
    total++;
    if (n_reads !== 2 || read_slot !== 48) begin
      bad++;
      $display("FAIL stream_reads: reads=%0d slot=%0d required 2/48", n_reads, read_slot);
    end
    total++;
    if (last_period !== 2 * BCLK_DIV) begin
      bad++;
      $display("FAIL bclk_period: got %0d clk required %0d", last_period, 2 * BCLK_DIV);
    end
  endtask

  task automatic test_underrun();
    logic [63:0] f;
    int n;
    wait_slot(0);
    f = (rx_q.size() > 0) ? rx_q.pop_front() : SENT;
    total++;
    if (f !== W2 || underrun_o !== 1'b1 || n_reads !== 2) begin
      bad++;
      $display("FAIL underrun_set: frame=%h ur=%b reads=%0d required %h/1/2", f, underrun_o, n_reads, W2);
    end
    wait_slot(0);
    f = (rx_q.size() > 0) ? rx_q.pop_front() : SENT;
    total++;
    if (f !== 64'h0 || underrun_o !== 1'b1) begin
      bad++;
      $display("FAIL underrun_zero_frame: frame=%h ur=%b required 0/1", f, underrun_o);
    end
    clr_pulse();
    total++;
    if (underrun_o !== 1'b0) begin
      bad++;
      $display("FAIL underrun_clear: got %b required 0", underrun_o);
    end
    // Land the clear pulse on the exact clk of the fall into slot 48.
    wait_slot(47);
    n = 0;
    do begin cycle(); n++; end while (i2s_bclk_o !== 1'b1 && n < 4 * BCLK_DIV);
    repeat (BCLK_DIV - 1) cycle();
    underrun_clr = 1'b1;
    cycle();
    underrun_clr = 1'b0;
    total++;
    if (!(fall_seen && slot == 48) || underrun_o !== 1'b1 || n_reads !== 2) begin
      bad++;
      $display("FAIL set_beats_clear: fall=%b slot=%0d ur=%b reads=%0d required 1/48/1/2",
               fall_seen, slot, underrun_o, n_reads);
    end
  endtask

  task automatic test_enable_drop();
    logic [63:0] f;
    int reads0;
    clr_pulse();
    wait_slot(20);
    total++;
    if (dbg.fetch_state !== FETCH_IDLE || dbg.slot !== 6'd20) begin
      bad++;
      $display("FAIL pre_drop_state: fetch=%0d slot=%0d required 0/20", dbg.fetch_state, dbg.slot);
    end
    enable = 1'b0;
    cycle();
    total++;
    if (i2s_bclk_o !== 1'b0 || i2s_lrclk_o !== 1'b1 || i2s_sdata_o !== 1'b0 || fifo_read_o !== 1'b0) begin
      bad++;
      $display("FAIL drop_idle: bclk=%b lr=%b sd=%b rd=%b required 0/1/0/0",
               i2s_bclk_o, i2s_lrclk_o, i2s_sdata_o, fifo_read_o);
    end
    restart_tracking(47);
    push(W3);
    push(W3 ^ 64'hFFFF_FFFF_FFFF_FFFF);
    reads0 = n_reads;
    repeat (9) cycle();
    total++;
    if (n_reads !== reads0 || i2s_lrclk_o !== 1'b1 || dbg.slot !== 6'd47) begin
      bad++;
      $display("FAIL idle_hold: reads=%0d lr=%b slot=%0d required %0d/1/47", n_reads, i2s_lrclk_o, dbg.slot, reads0);
    end
    enable = 1'b1;
    wait_slot(48);
    total++;
    if (n_reads !== reads0 + 1 || read_slot !== 48 || read_lag !== 0) begin
      bad++;
      $display("FAIL restart_fetch: reads=%0d slot=%0d lag=%0d required %0d/48/0", n_reads, read_slot, read_lag, reads0 + 1);
    end
    wait_slot(0);
    wait_slot(0);
    f = (rx_q.size() > 0) ? rx_q.pop_front() : SENT;
    total++;
    if (f !== 64'h0) begin
      bad++;
      $display("FAIL restart_lead_in: got %h required 0", f);
    end
    f = (rx_q.size() > 0) ? rx_q.pop_front() : SENT;
    total++;
    if (f !== W3) begin
      bad++;
      $display("FAIL restart_w3: got %h required %h", f, W3);
    end
  endtask

  task automatic test_drop_pending();
    logic [63:0] f;
    push(W5);
    push(W6);
    wait_slot(48);
    total++;
    if (fifo_read_o !== 1'b1) begin
      bad++;
      $display("FAIL pend_read: got %b required 1", fifo_read_o);
    end
    enable = 1'b0;
    cycle();
    cycle();
    total++;
    if (dbg.fetch_state !== FETCH_IDLE || i2s_sdata_o !== 1'b0) begin
      bad++;
      $display("FAIL pend_discard: fetch=%0d sd=%b required 0/0", dbg.fetch_state, i2s_sdata_o);
    end
    restart_tracking(47);
    repeat (4) cycle();
    enable = 1'b1;
    wait_slot(0);
    wait_slot(0);
    f = (rx_q.size() > 0) ? rx_q.pop_front() : SENT;
    total++;
    if (f !== 64'h0) begin
      bad++;
      $display("FAIL pend_lead_in: got %h required 0", f);
    end
    f = (rx_q.size() > 0) ? rx_q.pop_front() : SENT;
    total++;
    if (f !== W6) begin
      bad++;
      $display("FAIL no_stale_word: got %h required %h", f, W6);
    end
  endtask

  task automatic test_async_reset();
    logic [63:0] f;
    repeat (5) wait_slot((slot + 1) % 64);
    #3 reset = 1'b1;
    #1;
    total++;
    if ({fifo_read_o, i2s_bclk_o, i2s_lrclk_o, i2s_sdata_o, underrun_o} !== 5'b0) begin
      bad++;
      $display("FAIL async_reset: got rd/bclk/lr/sd/ur=%b required 00000",
               {fifo_read_o, i2s_bclk_o, i2s_lrclk_o, i2s_sdata_o, underrun_o});
    end
    prev_bclk = 1'b0;
    prev_rd   = 1'b0;
    fifo_q.delete();
    push(W7);
    cycle();
    cycle();
    reset = 1'b0;
    restart_tracking(0);
    n_reads = 0;
    wait_slot(0);
    total++;
    if (n_reads !== 1 || read_slot !== 48) begin
      bad++;
      $display("FAIL post_reset_fetch: reads=%0d slot=%0d required 1/48", n_reads, read_slot);
    end
    wait_slot(0);
    f = (rx_q.size() > 0) ? rx_q.pop_front() : SENT;
    total++;
    if (f !== 64'h0) begin
      bad++;
      $display("FAIL post_reset_lead_in: got %h required 0", f);
    end
    f = (rx_q.size() > 0) ? rx_q.pop_front() : SENT;
    total++;
    if (f !== W7) begin
      bad++;
      $display("FAIL post_reset_w7: got %h required %h", f, W7);
    end
  endtask

`ifdef I2S_TX_UNDERRUN_CNT_EN
  task automatic test_underrun_count();
    clr_pulse();
    total++;
    if (underrun_count !== 16'd0) begin
      bad++;
      $display("FAIL count_clear0: got %0d required 0", underrun_count);
    end
    repeat (3) wait_slot(48);
    total++;
    if (underrun_count !== 16'd3) begin
      bad++;
      $display("FAIL count_three: got %0d required 3", underrun_count);
    end
    force dut.underrun_cnt_q = 16'hFFFF;
    cycle();
    release dut.underrun_cnt_q;
    wait_slot(48);
    total++;
    if (underrun_count !== 16'hFFFF) begin
      bad++;
      $display("FAIL count_saturate: got %h required ffff", underrun_count);
    end
    clr_pulse();
    total++;
    if (underrun_count !== 16'd0 || underrun_o !== 1'b0) begin
      bad++;
      $display("FAIL count_clear: cnt=%0d ur=%b required 0/0", underrun_count, underrun_o);
    end
  endtask
`endif

  task automatic test_protocol();
    total++;
    if (lr_err !== 0) begin
      bad++;
      $display("FAIL lrclk_slot: %0d slots with wrong LRCLK required 0", lr_err);
    end
    total++;
    if (double_rd !== 0 || rd_empty !== 0 || read_while_off !== 0) begin
      bad++;
      $display("FAIL read_rules: double=%0d empty=%0d disabled=%0d required 0/0/0",
               double_rd, rd_empty, read_while_off);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    total = 0; bad = 0;
    slot = 0; cyc_since_fall = 0; last_period = 0;
    n_reads = 0; read_slot = -1; read_lag = -1;
    lr_err = 0; double_rd = 0; rd_empty = 0; read_while_off = 0;
    prev_bclk = 1'b0; prev_rd = 1'b0; fall_seen = 1'b0; got = '0;
    test_reset();
    test_stream();
    test_underrun();
    test_enable_drop();
    test_drop_pending();
    test_async_reset();
`ifdef I2S_TX_UNDERRUN_CNT_EN
    test_underrun_count();
`endif
    test_protocol();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/i2s_playback_tx.md
Name: i2s_playback_tx

Overview:
- Serializer at the read end of the playback FIFO. Consumes 64-bit stereo frames: left sample in [63:32], right sample in [31:0].
- Drives a master-mode I2S link: generates BCLK and LRCLK, outputs SDATA MSB-first with the standard one-BCLK delay after each LRCLK edge.
- Connects directly to playback_fifo_data, playback_fifo_read and playback_fifo_empty; runs on the FIFO read clock.

Parameters:
- BCLK_DIV, 4, clk cycles per BCLK half-period; legal range 2..255.

Ports:
- clk  in  1  FIFO read clock / block clock.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  level; 1 = transmit, 0 = idle.
- fifo_data  in  64  FIFO q, non-show-ahead: valid one clk after fifo_read.
- fifo_read  out  1  one-clk read pulse to FIFO.
- fifo_empty  in  1  FIFO read-side empty.
- i2s_bclk  out  1  bit clock.
- i2s_lrclk  out  1  word select; 0 = left, 1 = right.
- i2s_sdata  out  1  serial data.
- underrun  out  1  sticky underrun flag.
- underrun_clr  in  1  one-clk pulse; clears underrun.

Behaviour:
- Reset values: fifo_read=0, i2s_bclk=0, i2s_lrclk=0, i2s_sdata=0, underrun=0. Internal state: div_cnt=0, bit_cnt=0, shift=0, hold=0, fetch_pend=0.
- BCLK generation:
  - div_cnt counts 0..BCLK_DIV-1 while enable=1. At terminal count it wraps and i2s_bclk toggles.
  - A 0->1 toggle is a rise event; a 1->0 toggle is a fall event.
  - BCLK period = 2*BCLK_DIV clk.
- Slot timing:
  - bit_cnt (6 bits, 0..63) increments modulo 64 on each fall event. All outputs update on that same clk edge.
  - i2s_lrclk = bit_cnt[5], registered, so it changes on the falling BCLK edge.
- Data mapping:
  - On a fall event entering slot 1: shift <= hold, and i2s_sdata <= hold[63].
  - On fall events entering slots 2..63 and 0: shift shifts left by one, and i2s_sdata <= next MSB.
  - Result: slot k (1..63) carries frame bit 64-k; slot 0 carries bit 0 of the previous frame.
  - Left LSB (bit 32) therefore appears in slot 32, after LRCLK has gone high. This is the I2S delay.
- Fetch:
  - On the fall event entering slot 48: if fifo_empty=0, assert fifo_read for exactly one clk and set fetch_pend. The next clk captures hold <= fifo_data and clears fetch_pend.
  - If fifo_empty=1 at slot 48: no read is issued, hold <= 0, and underrun is set.
  - Timing requires 3 clk < one BCLK period, which BCLK_DIV>=2 guarantees.
- Underrun flag:
  - Setting is sticky.
  - underrun_clr clears it.
  - If set and clear occur in the same clk, set wins.
- Enable behaviour:
  - enable=0: synchronous return to idle. div_cnt=0, bit_cnt=47, i2s_bclk=0, i2s_lrclk=1, i2s_sdata=0, shift=0, hold=0, fetch_pend=0, fifo_read=0.
  - A word already read and still pending is discarded.
  - On enable 0->1, the first fall event enters slot 48, so the first fetch happens immediately.
  - SDATA is 0 for slots 48..63 and 0 of the lead-in; the first FIFO word starts at slot 1.
- Reset mid-operation: all state returns to reset values immediately, without waiting for a clk edge. Any pending read is abandoned.
- At most one fifo_read per 64-slot frame. fifo_read is never asserted while enable=0 or while fifo_empty=1.

Optional Feature:
- Macro I2S_TX_UNDERRUN_CNT_EN adds output port underrun_count [15:0].
  - The count increments on each underrun event and saturates at 16'hFFFF.
  - underrun_clr zeroes the count. If clear and an event occur in the same clk, the count becomes 1.
- Without the macro: no port, no counter logic. Flag behaviour is identical either way.

Decomposition:
- Package i2s_pkg holds:
  - FRAME_BITS=64, SLOT_FETCH=48, SLOT_LOAD=1, IDLE_SLOT=47.
  - The slot-counter width constant.
  - An enum for the fetch state: FETCH_IDLE, FETCH_PEND.
- One sub-module, i2s_bclk_gen:
  - Contains the divider, i2s_bclk, and one-clk rise/fall event strobes.
  - Inputs: clk, reset, enable.
  - Parameter: BCLK_DIV.

Test Plan:
1. BCLK_DIV=4, enable=1, FIFO holds 64'hA5A5_0001_8000_00FF → BCLK period 8 clk. LRCLK low for slots 0..31. SDATA slots 1..63 = bits 63..1, slot 0 of the next frame = bit 0 (1). Exactly one fifo_read per frame, at slot 48.
2. FIFO empty at slot 48 → no fifo_read. The next frame transmits all zeros. underrun=1 persists until an underrun_clr pulse. Clear and a new underrun in the same clk → underrun stays 1.
3. Drop enable at slot 20 with fetch idle, then raise it 10 clk later → outputs idle (bclk 0, lrclk 1, sdata 0) within 1 clk. On restart the first fetch occurs within 1 clk of the first fall event, and data starts at slot 1.
4. Drop enable in the clk between fifo_read and capture → the read word is discarded. After re-enable the next word comes from the FIFO; no stale data appears on SDATA.
5. Assert reset mid-frame → all outputs 0 immediately (async). The first frame after release behaves as in scenario 1.
6. With I2S_TX_UNDERRUN_CNT_EN: force 3 underruns → underrun_count=3. Preload the count to 16'hFFFF and underrun again → it holds 16'hFFFF. underrun_clr → 0.
